// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter
//   Round-robin arbiter that drives a one-hot select (plus its binary index)
//   toward a single consumer over a valid/ready handshake. While the consumer
//   stalls, the presented grant is frozen so the steered mux output is stable.
//
// Ports
//   clk        in   clock, all state updates on posedge
//   rst        in   synchronous reset, active-high
//   req        in   [N_REQS]  request vector, bit i from requester i
//   gnt_ready  in   consumer accepts the presented grant this cycle
//   gnt        out  [N_REQS]  one-hot grant, zero when gnt_valid is low
//   gnt_idx    out  [IDX_W]   binary index of the grant, zero when invalid
//   gnt_valid  out  a grant is presented
//
// state | meaning
// IDLE  | grant is a live combinational pick from req, searching up from ptr
// HOLD  | consumer stalled; grant frozen on hold_idx, req ignored
module onehot_rr_arbiter #(
    parameter int N_REQS = 4,
    parameter int IDX_W  = (N_REQS > 1) ? $clog2(N_REQS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQS-1:0] req,
    input  logic              gnt_ready,
    output logic [N_REQS-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   hold_idx_q, hold_idx_d;

    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;

    // Index after i, wrapping at N_REQS-1; ptr never leaves 0..N_REQS-1.
    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
        if (int'(i) >= N_REQS - 1) return '0;
        return i + IDX_W'(1);
    endfunction

    // Priority search starting at ptr_q and wrapping modulo N_REQS.
    always_comb begin
        int pos;
        win_idx   = '0;
        win_found = 1'b0;
        pos       = 0;
        for (int k = 0; k < N_REQS; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= N_REQS) pos = pos - N_REQS;
            if (!win_found && req[pos]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(pos);
            end
        end
    end

    // Reset forces the outputs low immediately, including a held grant.
    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        if (!rst) begin
            if (state_q == HOLD) begin
                sel_idx   = hold_idx_q;
                sel_valid = 1'b1;
            end else begin
                sel_idx   = win_idx;
                sel_valid = win_found;
            end
        end
    end

    always_comb begin
        gnt          = '0;
        gnt[sel_idx] = sel_valid;
        gnt_idx      = sel_idx;
        gnt_valid    = sel_valid;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_idx_d = hold_idx_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    if (gnt_ready) begin
                        ptr_d = inc_wrap(win_idx);
                    end else begin
                        hold_idx_d = win_idx;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (gnt_ready) begin
                    ptr_d   = inc_wrap(hold_idx_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_idx_q <= hold_idx_d;
        end
    end

    a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_valid  : assert property (@(posedge clk) disable iff (rst) gnt_valid == |gnt);
    a_index  : assert property (@(posedge clk) disable iff (rst)
                                gnt == (N_REQS'(gnt_valid) << gnt_idx));
    a_hold   : assert property (@(posedge clk) disable iff (rst)
                                (state_q == HOLD) |-> $stable(gnt));

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
module tb_onehot_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gnt_ready = 1'b0;
    logic [31:0] req = '0;

    always #5 clk = ~clk;

    logic [3:0] gnt_a;  logic [1:0] idx_a; logic val_a;
    logic [0:0] gnt_b;  logic [0:0] idx_b; logic val_b;
    logic [4:0] gnt_c;  logic [2:0] idx_c; logic val_c;

    onehot_rr_arbiter #(.N_REQS(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req[3:0]), .gnt_ready(gnt_ready),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a));

    onehot_rr_arbiter #(.N_REQS(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req[0:0]), .gnt_ready(gnt_ready),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b));

    onehot_rr_arbiter #(.N_REQS(5)) u_dut5 (
        .clk(clk), .rst(rst), .req(req[4:0]), .gnt_ready(gnt_ready),
        .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(val_c));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one entry per instance (N = 4, 1, 5).
    int nrq[3]    = '{4, 1, 5};
    int m_ptr[3]  = '{0, 0, 0};
    int m_held[3] = '{-1, -1, -1};
    int m_exp[3];

    logic [31:0] g_gnt[3];
    logic [31:0] g_idx[3];
    logic [31:0] g_val[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester at or after p, going round modulo n; -1 if none.
    function automatic int find_winner(input int n, input int p, input logic [31:0] r);
        for (int k = 0; k < n; k++)
            if (r[(p + k) % n]) return (p + k) % n;
        return -1;
    endfunction

    task automatic step(input logic [31:0] r, input logic rdy, input logic rs);
        logic [31:0] eg;
        req       = r;
        gnt_ready = rdy;
        rst       = rs;
        @(negedge clk);
        g_gnt[0] = 32'(gnt_a); g_idx[0] = 32'(idx_a); g_val[0] = 32'(val_a);
        g_gnt[1] = 32'(gnt_b); g_idx[1] = 32'(idx_b); g_val[1] = 32'(val_b);
        g_gnt[2] = 32'(gnt_c); g_idx[2] = 32'(idx_c); g_val[2] = 32'(val_c);
        for (int k = 0; k < 3; k++) begin
            if (rs)                m_exp[k] = -1;
            else if (m_held[k] >= 0) m_exp[k] = m_held[k];
            else                   m_exp[k] = find_winner(nrq[k], m_ptr[k], r);
            eg = (m_exp[k] >= 0) ? (32'd1 << m_exp[k]) : 32'd0;
            check_eq($sformatf("model_gnt_n%0d", nrq[k]), g_gnt[k], eg);
            check_eq($sformatf("model_idx_n%0d", nrq[k]), g_idx[k],
                     (m_exp[k] >= 0) ? 32'(m_exp[k]) : 32'd0);
            check_eq($sformatf("model_val_n%0d", nrq[k]), g_val[k], 32'(m_exp[k] >= 0));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rs) begin
                m_ptr[k]  = 0;
                m_held[k] = -1;
            end else if (m_exp[k] >= 0) begin
                if (rdy) begin
                    m_ptr[k]  = (m_exp[k] + 1) % nrq[k];
                    m_held[k] = -1;
                end else begin
                    m_held[k] = m_exp[k];
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] keep, nr;
        logic        rdy;
        int          wt[5];
        int          w;

        // Reset with requests present: outputs forced low.
        step(32'hF, 1'b0, 1'b1);
        step(32'hF, 1'b1, 1'b1);
        check_eq("rst_gnt", g_gnt[0], 32'd0);
        check_eq("rst_val", g_val[0], 32'd0);
        check_eq("rst_idx", g_idx[0], 32'd0);

        // Fairness: all requesting, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            step(32'hF, 1'b1, 1'b0);
            check_eq("fair_gnt", g_gnt[0], 32'd1 << (i % 4));
            check_eq("fair_idx", g_idx[0], 32'(i % 4));
        end

        // Pointer skip and wrap.
        step(32'h2, 1'b1, 1'b0);
        check_eq("to_idx1", g_gnt[0], 32'h2);
        step(32'h1, 1'b1, 1'b0);
        check_eq("wrap", g_gnt[0], 32'h1);
        step(32'h9, 1'b1, 1'b0);
        check_eq("skip", g_gnt[0], 32'h8);

        // Stall: grant frozen on idx 1 even after req[1] drops.
        step(32'h6, 1'b0, 1'b0);
        check_eq("hold_gnt0", g_gnt[0], 32'h2);
        step(32'h4, 1'b0, 1'b0);
        check_eq("hold_gnt1", g_gnt[0], 32'h2);
        step(32'h4, 1'b0, 1'b0);
        check_eq("hold_gnt2", g_gnt[0], 32'h2);
        step(32'h4, 1'b1, 1'b0);
        check_eq("hold_gnt3", g_gnt[0], 32'h2);
        check_eq("hold_idx3", g_idx[0], 32'd1);
        step(32'h6, 1'b1, 1'b0);
        check_eq("after_hold", g_gnt[0], 32'h4);

        // Idle: ready toggling with no requests must not move the pointer.
        for (int i = 0; i < 4; i++) begin
            step(32'h0, 1'(i % 2), 1'b0);
            check_eq("idle_val", g_val[0], 32'd0);
            check_eq("idle_gnt", g_gnt[0], 32'd0);
            check_eq("idle_idx", g_idx[0], 32'd0);
        end
        step(32'hF, 1'b1, 1'b0);
        check_eq("post_idle", g_gnt[0], 32'h8);

        // Reset while holding idx 2.
        step(32'h4, 1'b0, 1'b0);
        check_eq("hold2_a", g_gnt[0], 32'h4);
        step(32'hF, 1'b0, 1'b0);
        check_eq("hold2_b", g_gnt[0], 32'h4);
        step(32'hF, 1'b0, 1'b1);
        check_eq("rst_hold_gnt", g_gnt[0], 32'd0);
        check_eq("rst_hold_val", g_val[0], 32'd0);
        step(32'hF, 1'b1, 1'b0);
        check_eq("post_rst", g_gnt[0], 32'h1);

        // Single-requester build: hold then release.
        for (int i = 0; i < 3; i++) begin
            step(32'h1, 1'(i == 2), 1'b0);
            check_eq("n1_gnt", g_gnt[1], 32'd1);
            check_eq("n1_val", g_val[1], 32'd1);
            check_eq("n1_idx", g_idx[1], 32'd0);
        end
        step(32'h0, 1'b1, 1'b0);
        check_eq("n1_empty", g_val[1], 32'd0);

        // Random run, requests obey the contract for the 5-way instance.
        keep = '0;
        for (int i = 0; i < 5; i++) wt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            rdy = ($urandom_range(0, 9) < 6);
            nr  = keep | ($urandom & $urandom & 32'h1F);
            step(nr, rdy, 1'b0);
            w = m_exp[2];
            for (int i = 0; i < 5; i++)
                if (!nr[i]) wt[i] = 0;
            if (w >= 0 && rdy) begin
                check_eq("fair_bound", 32'(wt[w] <= 4), 32'd1);
                wt[w] = 0;
                for (int i = 0; i < 5; i++)
                    if (i != w && nr[i]) wt[i]++;
                keep = nr & ~(32'd1 << w);
            end else begin
                keep = nr;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
